// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - iterative AES key expansion, one schedule word per clock

// Forward AES S-box, one byte, purely combinational
module aesSbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SboxTable [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SboxTable[a];

endmodule

// Key expansion engine: IDLE loads the key words, RUN derives one word per clock
module key_schedule #(
  parameter int Nk = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [0:32*Nk-1]        Key,
  output logic [0:128*(Nk+7)-1]   RoundKeys,
  output logic                    busy,
  output logic                    done
);

  localparam int Nr         = Nk + 6;
  localparam int TotalWords = 4 * (Nr + 1);
  localparam int IdxW       = $clog2(TotalWords + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          stateQ;
  state_t          stateD;
  logic [31:0]     w [TotalWords];
  logic [IdxW-1:0] wordIdx;
  logic [2:0]      phase;
  logic [7:0]      rcon;

  logic [31:0]     prevWord;
  logic [31:0]     backWord;
  logic [31:0]     sboxIn;
  logic [31:0]     subOut;
  logic [31:0]     temp;
  logic [31:0]     newWord;
  logic            lastWord;

  // w[i-1] feeds the transform, w[i-Nk] is the XOR partner
  assign prevWord = w[wordIdx - IdxW'(1)];
  assign backWord = w[wordIdx - IdxW'(Nk)];
  assign sboxIn   = (phase == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
  assign lastWord = (wordIdx == IdxW'(TotalWords - 1));

  aesSbox sbox0 (.a(sboxIn[31:24]), .y(subOut[31:24]));
  aesSbox sbox1 (.a(sboxIn[23:16]), .y(subOut[23:16]));
  aesSbox sbox2 (.a(sboxIn[15:8]),  .y(subOut[15:8]));
  aesSbox sbox3 (.a(sboxIn[7:0]),   .y(subOut[7:0]));

  // Select the per-phase word transform; the extra SubWord only exists for 256-bit keys
  always_comb begin
    temp = prevWord;
    if (phase == 3'd0) begin
      temp = subOut ^ {rcon, 24'h0};
    end else if (Nk == 8 && phase == 3'd4) begin
      temp = subOut;
    end
    newWord = backWord ^ temp;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state: start is only honoured in IDLE, RUN ends on the final word
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (start) stateD = RUN;
      RUN:  if (lastWord) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Word array, index, phase and rcon; wordIdx parks at TotalWords when a run completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < TotalWords; j++) begin
        w[j] <= '0;
      end
      wordIdx <= '0;
      phase   <= '0;
      rcon    <= 8'h01;
    end else if (stateQ == IDLE && start) begin
      for (int j = 0; j < Nk; j++) begin
        w[j] <= Key[32*j +: 32];
      end
      wordIdx <= IdxW'(Nk);
      phase   <= '0;
      rcon    <= 8'h01;
    end else if (stateQ == RUN) begin
      w[wordIdx] <= newWord;
      wordIdx    <= wordIdx + IdxW'(1);
      phase      <= (phase == 3'(Nk - 1)) ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) begin
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // Outputs: done is derived from IDLE with a fully written schedule, so reset and a new start clear it
  always_comb begin
    busy = (stateQ == RUN);
    done = (stateQ == IDLE) && (wordIdx == IdxW'(TotalWords));
  end

  // Flatten the word array, w[0] at the most significant end
  always_comb begin
    RoundKeys = '0;
    for (int j = 0; j < TotalWords; j++) begin
      RoundKeys[32*j +: 32] = w[j];
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule at Nk = 4, 6, 8

module tb_key_schedule;

  localparam logic [127:0] KeyA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KeyA2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KeyA3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  startV;
  logic [0:255] keyV [3];
  wire  [2:0]  busyV;
  wire  [2:0]  doneV;
  wire  [0:1407] rk4;
  wire  [0:1663] rk6;
  wire  [0:1919] rk8;

  int vecs = 0;
  int miscompares = 0;
  logic cmpEn = 1'b0;

  // model state
  int          rem [3];
  logic        mDone [3];
  logic [31:0] modelW [3][60];
  logic [0:1919] fullV [3];

  always #5 clk = ~clk;

  key_schedule #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .start(startV[0]), .Key(keyV[0][0:127]),
                               .RoundKeys(rk4), .busy(busyV[0]), .done(doneV[0]));
  key_schedule #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .start(startV[1]), .Key(keyV[1][0:191]),
                               .RoundKeys(rk6), .busy(busyV[1]), .done(doneV[1]));
  key_schedule #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .start(startV[2]), .Key(keyV[2][0:255]),
                               .RoundKeys(rk8), .busy(busyV[2]), .done(doneV[2]));

  function automatic int nkOf(int s);
    return 4 + 2 * s;
  endfunction

  function automatic int totalOf(int s);
    return 4 * (nkOf(s) + 7);
  endfunction

  function automatic int latOf(int s);
    return totalOf(s) - nkOf(s);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = v << n;
    lo = v >> (8 - n);
    return hi | lo;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sboxOf(logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(logic [31:0] v);
    return {sboxOf(v[31:24]), sboxOf(v[23:16]), sboxOf(v[15:8]), sboxOf(v[7:0])};
  endfunction

  function automatic logic [7:0] rconOf(int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < n; k++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  // Whole schedule from the key, straight from the textbook recurrence
  function automatic logic [0:1919] expandKey(int nk, logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [0:1919] r;
    int total;
    total = 4 * (nk + 7);
    r = '0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subWord({t[23:0], t[31:24]}) ^ {rconOf(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = subWord(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < total; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] getWord(int s, int j);
    case (s)
      0: return rk4[32*j +: 32];
      1: return rk6[32*j +: 32];
      default: return rk8[32*j +: 32];
    endcase
  endfunction

  function automatic int countNz(int s);
    int n;
    n = 0;
    for (int j = 0; j < totalOf(s); j++) if (getWord(s, j) !== 32'h0) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: key captured on the accepting edge, then one precomputed word lands per edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        rem[s]   <= 0;
        mDone[s] <= 1'b0;
        for (int j = 0; j < 60; j++) modelW[s][j] <= 32'h0;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (rem[s] == 0) begin
          if (startV[s]) begin
            rem[s]   <= latOf(s);
            mDone[s] <= 1'b0;
            fullV[s] <= expandKey(nkOf(s), keyV[s]);
            for (int j = 0; j < nkOf(s); j++) modelW[s][j] <= keyV[s][32*j +: 32];
          end
        end else begin
          modelW[s][nkOf(s) + latOf(s) - rem[s]] <= fullV[s][32*(nkOf(s) + latOf(s) - rem[s]) +: 32];
          rem[s] <= rem[s] - 1;
          if (rem[s] == 1) mDone[s] <= 1'b1;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    int bad;
    if (cmpEn) begin
      for (int s = 0; s < 3; s++) begin
        vecs++;
        if (busyV[s] !== (rem[s] != 0)) begin
          miscompares++;
          $display("FAIL busy[Nk=%0d]: got %b expected %b", nkOf(s), busyV[s], rem[s] != 0);
        end
        vecs++;
        if (doneV[s] !== mDone[s]) begin
          miscompares++;
          $display("FAIL done[Nk=%0d]: got %b expected %b", nkOf(s), doneV[s], mDone[s]);
        end
        vecs++;
        if (busyV[s] && doneV[s]) begin
          miscompares++;
          $display("FAIL busy_and_done[Nk=%0d]: got 1 expected 0", nkOf(s));
        end
        vecs++;
        bad = -1;
        for (int j = 0; j < totalOf(s); j++) begin
          if (bad < 0 && getWord(s, j) !== modelW[s][j]) bad = j;
        end
        if (bad >= 0) begin
          miscompares++;
          $display("FAIL words[Nk=%0d] w[%0d]: got %h expected %h", nkOf(s), bad, getWord(s, bad), modelW[s][bad]);
        end
      end
    end
  end

  // Pulse start from a point between edges, then time done and busy against the expected latency
  task automatic runStart(input int s, input logic [0:255] key);
    int cnt;
    int busyCnt;
    keyV[s]   = key;
    startV[s] = 1'b1;
    @(posedge clk);
    #1;
    startV[s] = 1'b0;
    cnt = 0;
    busyCnt = 0;
    while (!doneV[s] && cnt < 200) begin
      if (busyV[s]) busyCnt++;
      @(posedge clk);
      #1;
      cnt++;
    end
    check($sformatf("done_latency[Nk=%0d]", nkOf(s)), 128'(cnt), 128'(latOf(s)));
    check($sformatf("busy_cycles[Nk=%0d]", nkOf(s)), 128'(busyCnt), 128'(latOf(s)));
  endtask

  task automatic waitDone(input int s);
    int cnt;
    cnt = 0;
    while (!doneV[s] && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check($sformatf("wait_done[Nk=%0d]", nkOf(s)), 128'(doneV[s]), 128'(1));
  endtask

  initial begin
    logic [0:1919] mv;
    int cnt;
    reset  = 1'b1;
    startV = 3'b000;
    for (int s = 0; s < 3; s++) keyV[s] = '0;

    // model pinned against published vectors
    mv = expandKey(4, {KeyA1, 128'h0});
    check("model_A1_w4", mv[32*4 +: 32], 32'ha0fafe17);
    check("model_A1_rk10", mv[32*40 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    mv = expandKey(8, KeyA3);
    check("model_A3_w56", mv[32*56 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_busy[Nk=%0d]", nkOf(s)), 128'(busyV[s]), 128'(0));
      check($sformatf("reset_done[Nk=%0d]", nkOf(s)), 128'(doneV[s]), 128'(0));
      check($sformatf("reset_words[Nk=%0d]", nkOf(s)), 128'(countNz(s)), 128'(0));
    end
    reset = 1'b0;
    cmpEn = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 A.1, A.2, A.3
    runStart(0, {KeyA1, 128'h0});
    check("A1_w4", getWord(0, 4), 32'ha0fafe17);
    check("A1_rk10", {getWord(0, 40), getWord(0, 41), getWord(0, 42), getWord(0, 43)},
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    runStart(1, {KeyA2, 64'h0});
    check("A2_w6", getWord(1, 6), 32'hfe0c91f7);
    check("A2_w48", {getWord(1, 48), getWord(1, 49), getWord(1, 50), getWord(1, 51)},
          128'he98ba06f448c773c8ecc720401002202);
    runStart(2, KeyA3);
    check("A3_w8", getWord(2, 8), 32'h9ba35411);
    check("A3_w56", {getWord(2, 56), getWord(2, 57), getWord(2, 58), getWord(2, 59)},
          128'hfe4890d1e6188d0b046df344706c631e);

    // start held high, key disturbed at E5
    keyV[0]   = {KeyA1, 128'h0};
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    keyV[0] = '1;
    cnt = 5;
    while (!doneV[0] && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("hold_latency", 128'(cnt), 128'(40));
    check("hold_rk10", {getWord(0, 40), getWord(0, 41), getWord(0, 42), getWord(0, 43)},
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk);
    #1;
    check("reaccept_done", 128'(doneV[0]), 128'(0));
    check("reaccept_busy", 128'(busyV[0]), 128'(1));
    startV[0] = 1'b0;
    waitDone(0);

    // asynchronous abort at E20
    keyV[0]   = {KeyA1, 128'h0};
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 128'(busyV[0]), 128'(0));
    check("abort_done", 128'(doneV[0]), 128'(0));
    check("abort_words", 128'(countNz(0)), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    runStart(0, {KeyA1, 128'h0});
    check("post_abort_rk10", {getWord(0, 40), getWord(0, 41), getWord(0, 42), getWord(0, 43)},
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back with an all-zero key
    runStart(0, '0);
    check("zero_rk10", {getWord(0, 40), getWord(0, 41), getWord(0, 42), getWord(0, 43)},
          128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    @(posedge clk);
    #1;
    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
